// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall controller for a 5-stage MIPS pipeline, with multi-cycle
// multiply/divide occupancy tracking. Define HZ_PERF_CNT_EN to build the perf counters.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MDU_LAT    = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs_iss_hz_i,
  input  logic [REG_ADDR_W-1:0] rt_iss_hz_i,
  input  logic [REG_ADDR_W-1:0] rs_ex_hz_i,
  input  logic [REG_ADDR_W-1:0] rt_ex_hz_i,
  input  logic [REG_ADDR_W-1:0] rd_ex_hz_i,
  input  logic                  reg_wr_ex_hz_i,
  input  logic                  mem_to_reg_ex_hz_i,
  input  logic [REG_ADDR_W-1:0] rd_mem_hz_i,
  input  logic                  reg_wr_mem_hz_i,
  input  logic [REG_ADDR_W-1:0] rd_wb_hz_i,
  input  logic                  reg_wr_wb_hz_i,
  input  logic                  valid_wb_hz_i,
  input  logic                  mdu_start_ex_hz_i,
  input  logic                  branch_taken_ex_hz_i,
  input  logic                  jump_iss_hz_i,
  output logic                  stall_fetch_hz_o,
  output logic                  stall_iss_hz_o,
  output logic                  stall_ex_hz_o,
  output logic                  flush_iss_hz_o,
  output logic                  flush_ex_hz_o,
  output logic                  flush_mem_hz_o,
  output logic [1:0]            fwd_p1_hz_o,
  output logic [1:0]            fwd_p2_hz_o,
  output logic                  mdu_busy_hz_o,
  output logic [CNT_W-1:0]      retired_cnt_hz_o,
  output logic [CNT_W-1:0]      stall_cnt_hz_o
);

  // Width kept at least 1 so MDU_LAT values of 1 and 2 still elaborate.
  localparam int unsigned CntW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} mdu_state_e;

  mdu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mdu_accept, mdu_stall, load_use;

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                         input logic                  wr_mem,
                                         input logic [REG_ADDR_W-1:0] rd_mem,
                                         input logic                  wr_wb,
                                         input logic [REG_ADDR_W-1:0] rd_wb);
    if (wr_mem && (rd_mem != '0) && (rd_mem == src)) return 2'b10;
    if (wr_wb && (rd_wb != '0) && (rd_wb == src))    return 2'b01;
    return 2'b00;
  endfunction

  assign load_use = mem_to_reg_ex_hz_i && reg_wr_ex_hz_i && (rd_ex_hz_i != '0) &&
                    ((rd_ex_hz_i == rs_iss_hz_i) || (rd_ex_hz_i == rt_iss_hz_i));

  // DONE ignores mdu_start: the finishing instruction is still sitting in EX.
  assign mdu_accept = (MDU_LAT > 1) && (state_q == StIdle) && mdu_start_ex_hz_i &&
                      !branch_taken_ex_hz_i;
  assign mdu_stall  = mdu_accept || (state_q == StBusy);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (mdu_accept) begin
          if (MDU_LAT == 2) begin
            state_d = StDone;
          end else begin
            state_d = StBusy;
            cnt_d   = CntW'(MDU_LAT - 2);
          end
        end
      end
      StBusy: begin
        if (cnt_q == CntW'(1)) state_d = StDone;
        else                   cnt_d   = cnt_q - CntW'(1);
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mdu_busy_hz_o = (state_q != StIdle);

  always_comb begin
    stall_fetch_hz_o = 1'b0;
    stall_iss_hz_o   = 1'b0;
    stall_ex_hz_o    = 1'b0;
    flush_iss_hz_o   = 1'b0;
    flush_ex_hz_o    = 1'b0;
    flush_mem_hz_o   = 1'b0;
    fwd_p1_hz_o      = 2'b00;
    fwd_p2_hz_o      = 2'b00;
    if (!reset) begin
      flush_iss_hz_o = 1'b1;
      flush_ex_hz_o  = 1'b1;
      flush_mem_hz_o = 1'b1;
    end else begin
      fwd_p1_hz_o = fwd_sel(rs_ex_hz_i, reg_wr_mem_hz_i, rd_mem_hz_i, reg_wr_wb_hz_i, rd_wb_hz_i);
      fwd_p2_hz_o = fwd_sel(rt_ex_hz_i, reg_wr_mem_hz_i, rd_mem_hz_i, reg_wr_wb_hz_i, rd_wb_hz_i);
      // A taken branch kills everything younger, so no stall is worth honouring.
      if (branch_taken_ex_hz_i) begin
        flush_iss_hz_o = 1'b1;
        flush_ex_hz_o  = 1'b1;
      end else if (mdu_stall) begin
        stall_fetch_hz_o = 1'b1;
        stall_iss_hz_o   = 1'b1;
        stall_ex_hz_o    = 1'b1;
        flush_mem_hz_o   = 1'b1;
      end else if (load_use) begin
        stall_fetch_hz_o = 1'b1;
        stall_iss_hz_o   = 1'b1;
        flush_ex_hz_o    = 1'b1;
      end else if (jump_iss_hz_i) begin
        flush_iss_hz_o = 1'b1;
      end
    end
  end

`ifdef HZ_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q, stall_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_q + CNT_W'(valid_wb_hz_i);
      stall_q   <= stall_q + CNT_W'(stall_fetch_hz_o);
    end
  end

  assign retired_cnt_hz_o = retired_q;
  assign stall_cnt_hz_o   = stall_q;
`else
  logic unused_valid_wb;
  assign unused_valid_wb  = valid_wb_hz_i;
  assign retired_cnt_hz_o = '0;
  assign stall_cnt_hz_o   = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed literal checks plus randomized traffic compared every
// cycle against an occupancy-count model of the hazard rules.
module tb_pipe_hazard_ctrl;
  localparam int AW  = 5;
  localparam int LAT = 4;
  localparam int CW  = 32;
`ifdef HZ_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] rs_iss, rt_iss, rs_ex, rt_ex, rd_ex, rd_mem, rd_wb;
  logic reg_wr_ex, mem_to_reg_ex, reg_wr_mem, reg_wr_wb, valid_wb, mdu_start, branch, jump;
  logic sf, si, se, fi, fe, fm, busy;
  logic [1:0] p1, p2;
  logic [CW-1:0] ret_cnt, stl_cnt;
  logic sf2, si2, se2, fi2, fe2, fm2, busy2;
  logic [1:0] p1b, p2b;
  logic [CW-1:0] ret_cnt2, stl_cnt2;

  pipe_hazard_ctrl #(.REG_ADDR_W(AW), .MDU_LAT(LAT), .CNT_W(CW)) u_dut (
    .clk(clk), .reset(reset),
    .rs_iss_hz_i(rs_iss), .rt_iss_hz_i(rt_iss), .rs_ex_hz_i(rs_ex), .rt_ex_hz_i(rt_ex),
    .rd_ex_hz_i(rd_ex), .reg_wr_ex_hz_i(reg_wr_ex), .mem_to_reg_ex_hz_i(mem_to_reg_ex),
    .rd_mem_hz_i(rd_mem), .reg_wr_mem_hz_i(reg_wr_mem), .rd_wb_hz_i(rd_wb),
    .reg_wr_wb_hz_i(reg_wr_wb), .valid_wb_hz_i(valid_wb), .mdu_start_ex_hz_i(mdu_start),
    .branch_taken_ex_hz_i(branch), .jump_iss_hz_i(jump),
    .stall_fetch_hz_o(sf), .stall_iss_hz_o(si), .stall_ex_hz_o(se),
    .flush_iss_hz_o(fi), .flush_ex_hz_o(fe), .flush_mem_hz_o(fm),
    .fwd_p1_hz_o(p1), .fwd_p2_hz_o(p2), .mdu_busy_hz_o(busy),
    .retired_cnt_hz_o(ret_cnt), .stall_cnt_hz_o(stl_cnt)
  );

  // Second instance with a 2-cycle MDU, sharing all inputs.
  pipe_hazard_ctrl #(.REG_ADDR_W(AW), .MDU_LAT(2), .CNT_W(CW)) u_dut2 (
    .clk(clk), .reset(reset),
    .rs_iss_hz_i(rs_iss), .rt_iss_hz_i(rt_iss), .rs_ex_hz_i(rs_ex), .rt_ex_hz_i(rt_ex),
    .rd_ex_hz_i(rd_ex), .reg_wr_ex_hz_i(reg_wr_ex), .mem_to_reg_ex_hz_i(mem_to_reg_ex),
    .rd_mem_hz_i(rd_mem), .reg_wr_mem_hz_i(reg_wr_mem), .rd_wb_hz_i(rd_wb),
    .reg_wr_wb_hz_i(reg_wr_wb), .valid_wb_hz_i(valid_wb), .mdu_start_ex_hz_i(mdu_start),
    .branch_taken_ex_hz_i(branch), .jump_iss_hz_i(jump),
    .stall_fetch_hz_o(sf2), .stall_iss_hz_o(si2), .stall_ex_hz_o(se2),
    .flush_iss_hz_o(fi2), .flush_ex_hz_o(fe2), .flush_mem_hz_o(fm2),
    .fwd_p1_hz_o(p1b), .fwd_p2_hz_o(p2b), .mdu_busy_hz_o(busy2),
    .retired_cnt_hz_o(ret_cnt2), .stall_cnt_hz_o(stl_cnt2)
  );

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: phase counts cycles since the MDU instruction was accepted (0 = nothing in flight).
  int phase = 0;
  logic [CW-1:0] m_ret = '0;
  logic [CW-1:0] m_stl = '0;

  function automatic logic [1:0] m_fwd(input logic [AW-1:0] src);
    if (reg_wr_mem && rd_mem != 0 && rd_mem == src) return 2'd2;
    if (reg_wr_wb && rd_wb != 0 && rd_wb == src)    return 2'd1;
    return 2'd0;
  endfunction

  always @(negedge clk) begin
    logic lu, acc, ms, e_sf, e_si, e_se, e_fi, e_fe, e_fm;
    logic [1:0] e_p1, e_p2;
    if (chk_en) begin
      lu  = mem_to_reg_ex && reg_wr_ex && rd_ex != 0 && (rd_ex == rs_iss || rd_ex == rt_iss);
      acc = (phase == 0) && mdu_start && !branch && (LAT > 1);
      ms  = acc || (phase >= 1 && phase <= LAT - 2);
      {e_sf, e_si, e_se, e_fi, e_fe, e_fm} = '0;
      e_p1 = 2'd0;
      e_p2 = 2'd0;
      if (!reset) begin
        {e_fi, e_fe, e_fm} = 3'b111;
      end else begin
        e_p1 = m_fwd(rs_ex);
        e_p2 = m_fwd(rt_ex);
        if (branch)     {e_fi, e_fe} = 2'b11;
        else if (ms)    {e_sf, e_si, e_se, e_fm} = 4'b1111;
        else if (lu)    {e_sf, e_si, e_fe} = 3'b111;
        else if (jump)  e_fi = 1'b1;
      end
      chk("m_stall_fetch", sf, e_sf);
      chk("m_stall_iss", si, e_si);
      chk("m_stall_ex", se, e_se);
      chk("m_flush_iss", fi, e_fi);
      chk("m_flush_ex", fe, e_fe);
      chk("m_flush_mem", fm, e_fm);
      chk("m_fwd_p1", p1, e_p1);
      chk("m_fwd_p2", p2, e_p2);
      chk("m_mdu_busy", busy, phase != 0);
      chk("m_retired_cnt", ret_cnt, m_ret);
      chk("m_stall_cnt", stl_cnt, m_stl);
      if (!reset) begin
        phase = 0;
        m_ret = '0;
        m_stl = '0;
      end else begin
        if (phase == 0)            phase = acc ? 1 : 0;
        else if (phase + 1 <= LAT - 1) phase = phase + 1;
        else                       phase = 0;
        if (PerfEn) begin
          m_ret = m_ret + CW'(valid_wb);
          m_stl = m_stl + CW'(e_sf);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    {rs_iss, rt_iss, rs_ex, rt_ex, rd_ex, rd_mem, rd_wb} = '0;
    {reg_wr_ex, mem_to_reg_ex, reg_wr_mem, reg_wr_wb, valid_wb, mdu_start, branch, jump} = '0;
  endtask

  task automatic set_load_use();
    mem_to_reg_ex = 1'b1;
    reg_wr_ex     = 1'b1;
    rd_ex         = 5'd8;
    rt_iss        = 5'd8;
  endtask

  bit exp_se4[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  bit exp_bz4[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  bit exp_se2[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [CW-1:0] exp_ret10;

  initial begin
    exp_ret10 = PerfEn ? CW'(10) : CW'(0);
    clear_in();
    reset = 1'b0;
    step();
    chk_en = 1'b1;
    chk("rst_flush_iss", fi, 1);
    chk("rst_flush_mem", fm, 1);
    chk("rst_stall_fetch", sf, 0);
    step();
    reset = 1'b1;
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_flush_iss", fi, 0);

    // Forwarding
    step();
    rd_mem = 5; rd_wb = 5; rs_ex = 5; reg_wr_mem = 1; reg_wr_wb = 1;
    #1 chk("fwd_mem_wins", p1, 2'b10);
    rd_mem = 0;
    #1 chk("fwd_wb", p1, 2'b01);
    rt_ex = 0; rd_wb = 0;
    #1 chk("fwd_r0", p2, 2'b00);
    step();
    clear_in();

    // Load-use
    step();
    set_load_use();
    #1;
    chk("lu_stall_fetch", sf, 1);
    chk("lu_stall_iss", si, 1);
    chk("lu_flush_ex", fe, 1);
    chk("lu_stall_ex", se, 0);
    step();
    rd_ex = 0;
    #1 chk("lu_r0_no_stall", sf, 0);
    step();
    clear_in();

    // MDU occupancy, both latencies
    for (int k = 0; k < 4; k++) begin
      step();
      mdu_start = 1'b1;
      #1;
      chk("mdu4_stall_ex", se, exp_se4[k]);
      chk("mdu4_flush_mem", fm, exp_se4[k]);
      chk("mdu4_busy", busy, exp_bz4[k]);
      chk("mdu2_stall_ex", se2, exp_se2[k]);
    end
    step();
    mdu_start = 1'b0;
    #1;
    chk("mdu4_idle", busy, 0);
    chk("mdu2_idle", busy2, 0);

    // Branch beats load-use and MDU start
    step();
    set_load_use();
    branch = 1'b1;
    mdu_start = 1'b1;
    #1;
    chk("br_flush_iss", fi, 1);
    chk("br_flush_ex", fe, 1);
    chk("br_stall_fetch", sf, 0);
    chk("br_stall_ex", se, 0);
    step();
    clear_in();
    #1 chk("br_no_mdu", busy, 0);

    // Jump held during load-use stall
    step();
    set_load_use();
    jump = 1'b1;
    #1;
    chk("jmp_held", fi, 0);
    chk("jmp_held_stall", sf, 1);
    step();
    mem_to_reg_ex = 1'b0;
    #1;
    chk("jmp_release", fi, 1);
    chk("jmp_release_stall", sf, 0);
    step();
    clear_in();

    // Reset mid-MDU, then retire count
    step();
    mdu_start = 1'b1;
    #1 chk("rmdu_stall", se, 1);
    step();
    reset = 1'b0;
    #1;
    chk("rmdu_rst_stall", se, 0);
    chk("rmdu_rst_busy", busy, 1);
    step();
    reset = 1'b1;
    mdu_start = 1'b0;
    #1;
    chk("rmdu_idle", busy, 0);
    chk("rmdu_no_stall", sf, 0);
    chk("rmdu_ret0", ret_cnt, 0);
    chk("rmdu_stl0", stl_cnt, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      valid_wb = 1'b1;
    end
    step();
    valid_wb = 1'b0;
    #1 chk("retired_10", ret_cnt, exp_ret10);

    // Randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      step();
      reset         = ($urandom_range(0, 63) != 0);
      rs_iss        = AW'($urandom_range(0, 3));
      rt_iss        = AW'($urandom_range(0, 3));
      rs_ex         = AW'($urandom_range(0, 3));
      rt_ex         = AW'($urandom_range(0, 3));
      rd_ex         = AW'($urandom_range(0, 3));
      rd_mem        = AW'($urandom_range(0, 3));
      rd_wb         = AW'($urandom_range(0, 3));
      reg_wr_ex     = 1'($urandom);
      mem_to_reg_ex = 1'($urandom);
      reg_wr_mem    = 1'($urandom);
      reg_wr_wb     = 1'($urandom);
      valid_wb      = 1'($urandom);
      mdu_start     = ($urandom_range(0, 5) == 0);
      branch        = ($urandom_range(0, 7) == 0);
      jump          = ($urandom_range(0, 3) == 0);
    end
    step();
    clear_in();
    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

- Parametrised hazard, forwarding and stall controller for the 5-stage MIPS pipeline: FETCH, ISS, EX, MEM, WB.
- Adds three things to the plain forward/flush logic:
  - load-use stall detection against the ISS-stage source registers;
  - a multi-cycle multiply/divide (MDU) occupancy FSM that holds EX for a configurable latency;
  - optional performance counters.
- Sits beside the pipeline registers and drives their hold/clear controls and the EX operand forwarding muxes.

## Interface

Parameters:
- REG_ADDR_W, 5, register specifier width
- MDU_LAT, 4, cycles an MDU instruction occupies EX (1 = MDU stalling disabled)
- CNT_W, 32, perf counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- rs_iss_hz_i, rt_iss_hz_i  in  REG_ADDR_W  ISS-stage source registers
- rs_ex_hz_i, rt_ex_hz_i  in  REG_ADDR_W  EX-stage source registers
- rd_ex_hz_i  in  REG_ADDR_W  EX destination
- reg_wr_ex_hz_i  in  1  EX instruction writes a register
- mem_to_reg_ex_hz_i  in  1  EX instruction is a load
- rd_mem_hz_i  in  REG_ADDR_W  MEM destination
- reg_wr_mem_hz_i  in  1  MEM register write
- rd_wb_hz_i  in  REG_ADDR_W  WB destination
- reg_wr_wb_hz_i  in  1  WB register write
- valid_wb_hz_i  in  1  valid instruction retiring this cycle
- mdu_start_ex_hz_i  in  1  EX instruction is MDU
- branch_taken_ex_hz_i  in  1  branch resolved taken in EX
- jump_iss_hz_i  in  1  jump decoded in ISS
- stall_fetch_hz_o  out  1  hold PC register
- stall_iss_hz_o  out  1  hold FETCH/ISS register
- stall_ex_hz_o  out  1  hold ISS/EX register
- flush_iss_hz_o  out  1  clear FETCH/ISS register
- flush_ex_hz_o  out  1  clear ISS/EX register
- flush_mem_hz_o  out  1  clear EX/MEM register
- fwd_p1_hz_o, fwd_p2_hz_o  out  2  operand source:
  - 2'b10 = MEM ALU result
  - 2'b01 = WB write data
  - 2'b00 = register file
- mdu_busy_hz_o  out  1  FSM not IDLE
- retired_cnt_hz_o  out  CNT_W  retired instruction count
- stall_cnt_hz_o  out  CNT_W  cycles with stall_fetch_hz_o=1

## Operation

- **Forwarding** (combinational), p1 compares rs_ex, p2 compares rt_ex:
  - 2'b10 if reg_wr_mem & rd_mem≠0 & rd_mem==src;
  - else 2'b01 if reg_wr_wb & rd_wb≠0 & rd_wb==src;
  - else 2'b00.
  - MEM match wins over WB match.
- **Load-use (lu):** condition is mem_to_reg_ex & reg_wr_ex & rd_ex≠0 & (rd_ex==rs_iss | rd_ex==rt_iss). Response: stall_fetch=1, stall_iss=1, flush_ex=1 (bubble into EX).
- **MDU FSM:** states IDLE, BUSY, DONE; counter cnt of width clog2(MDU_LAT).
  - IDLE & mdu_start & ~branch_taken: stall asserted this cycle.
    - Next state DONE if MDU_LAT==2.
    - Otherwise next state BUSY with cnt=MDU_LAT-2.
  - BUSY: stall asserted. If cnt==1, next state DONE; otherwise cnt decrements.
  - DONE: no MDU stall; mdu_start is ignored (same instruction still in EX); next state IDLE.
  - MDU stall drives stall_fetch=stall_iss=stall_ex=1 and flush_mem=1.
  - MDU_LAT==1: FSM stays IDLE.
- **Branch taken:** flush_iss=1, flush_ex=1, no stalls.
- **Jump in ISS:** flush_iss=1.
- **Priority**, highest first: reset > branch_taken > MDU stall > load-use > jump.
  - Branch suppresses load-use stall and the MDU start.
  - Any active stall suppresses the jump flush (jump held in ISS, flushes when released).
- **Reset (reset=0):**
  - all stalls 0;
  - flush_iss/ex/mem = 1;
  - fwd = 00;
  - FSM to IDLE, cnt = 0, mdu_busy = 0;
  - counters = 0.

## Timing

- Forward, stall and flush outputs are combinational from the current-cycle inputs and FSM state; the pipeline registers act on the next clk edge.
- FSM state, cnt and counters update on the clk rising edge.
- An MDU instruction entering EX in cycle T:
  - stalls T..T+MDU_LAT-2 (MDU_LAT-1 cycles);
  - advances to MEM at the end of cycle T+MDU_LAT-1.
- mdu_busy_hz_o = 1 in BUSY and DONE (registered state; low in the start cycle).
- Counters wrap modulo 2^CNT_W.
- Deasserting reset mid-MDU returns to IDLE; no stall on the first post-reset cycle unless a hazard input is present.

## Configuration

- HZ_PERF_CNT_EN defined:
  - retired_cnt increments on each valid_wb_hz_i=1 cycle;
  - stall_cnt increments on each stall_fetch_hz_o=1 cycle.
- HZ_PERF_CNT_EN undefined: no counter flops; both outputs are constant 0.

## Test plan

- **Forwarding:** rd_mem=rd_wb=rs_ex=5, both reg_wr=1 -> fwd_p1=2'b10. Then rd_mem=0 -> fwd_p1=2'b01. Then rt_ex=0 with matching rd=0 -> fwd_p2=2'b00.
- **Load-use:** load in EX with rd_ex=8, rt_iss=8 -> one cycle of stall_fetch=stall_iss=flush_ex=1. Same with rd_ex=0 -> no stall.
- **MDU, MDU_LAT=4:** mdu_start held 4 cycles from T -> stall_ex=1 at T, T+1, T+2, 0 at T+3; flush_mem=1 for those 3 cycles; mdu_busy=1 at T+1..T+3; IDLE at T+4. Repeat with MDU_LAT=2 -> single stall cycle.
- **Branch vs load-use:** branch_taken and a load-use condition in the same cycle -> flush_iss=flush_ex=1, all stalls 0, FSM not started.
- **Jump during load-use stall:** jump_iss during load-use -> flush_iss=0 while stalled, 1 in the first unstalled cycle.
- **Reset mid-MDU:** reset=0 at T+1 of an MDU sequence -> next cycle IDLE, all stalls 0. With HZ_PERF_CNT_EN, counters read 0, then 10 valid_wb pulses -> retired_cnt=10.
